// File: rtl/decoder_pkg.sv
// Shared decoder definitions: FSM state encoding, active-low one-hot helper, enable decode.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
//
// Contents:
//   state_t        - ST_IDLE / ST_DIRECT / ST_SCAN encoding
//   onehot_n()     - ~(1 << addr) over MAX_OUT_N bits; callers slice to their own width
//   enable_decode() - three-input enable (two active-low, one active-high)
package decoder_pkg;

    // Widest address any decoder in this family supports.
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_OUT_N  = 1 << MAX_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Active-low one-hot: every bit high except bit 'addr'.
    function automatic logic [MAX_OUT_N-1:0] onehot_n(input logic [MAX_ADDR_W-1:0] addr);
        logic [MAX_OUT_N-1:0] v;
        v       = '1;
        v[addr] = 1'b0;
        return v;
    endfunction

    // Decoder is live only with en3 high and both active-low enables low.
    function automatic logic enable_decode(input logic en1_n, input logic en2_n, input logic en3);
        return en3 & ~en1_n & ~en2_n;
    endfunction

endpackage

// File: rtl/decoder_scan_timer.sv
// Dwell timer: DWELL_W down-counter with load, flags the last cycle of a dwell period.
// Latency: load takes effect on the next edge; done is a decode of the count register.
// Backpressure: none; counts only while run is high, holds otherwise.
//
// Ports:
//   clk, rst_n - clock, async active-low reset (count clears to 0)
//   run        - count down while high; done is suppressed while low
//   load       - load load_val (takes priority over counting)
//   load_val   - dwell value to load
//   done       - high in the last cycle of the current dwell period
module scan_timer
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               done
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && (count != '0)) begin
            count <= count - DWELL_W'(1);
        end
    end

    // A loaded value of N gives N+1 cycles before done is seen.
    assign done = run && (count == '0);

endmodule

// File: rtl/decoder_scan.sv
// N-to-2^N registered decoder with active-low one-hot outputs, direct and scan modes.
// Latency: 1 cycle from accept/advance to y_n; enable or mode change costs one all-ones cycle.
// Backpressure: addr_ready is a registered decode of the DIRECT state, never of addr_valid.
//
// Ports:
//   clk, rst_n          - clock, async active-low reset (outputs go all-ones at once)
//   en1_n, en2_n, en3   - enable gating; decoder live only for 0/0/1
//   mode                - 0 direct decode, 1 autonomous scan
//   addr_valid/addr     - direct-mode address handshake with addr_ready
//   dwell               - scan: each address held dwell+1 cycles (sampled at each load)
//   scan_last           - scan: highest address before returning to 0
//   y_n                 - active-low one-hot outputs, all-ones when nothing selected
//   cur_addr            - index of the low y_n bit, 0 when none
//   wrap                - one-cycle pulse on the first cycle of address 0 after scan_last
module decoder_scan
    import decoder_pkg::*;
#(
    parameter  int ADDR_W  = 3,
    parameter  int DWELL_W = 8,
    localparam int OUT_N   = 1 << ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en1_n,
    input  logic               en2_n,
    input  logic               en3,
    input  logic               mode,
    input  logic               addr_valid,
    input  logic [ADDR_W-1:0]  addr,
    output logic               addr_ready,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [ADDR_W-1:0]  scan_last,
    output logic [OUT_N-1:0]   y_n,
    output logic [ADDR_W-1:0]  cur_addr,
    output logic               wrap
);

    state_t               state;
    logic                 enable;
    logic                 tmr_done;
    logic                 tmr_load;
    logic                 scan_to_zero;
    logic [ADDR_W-1:0]    scan_next;
    logic [ADDR_W-1:0]    load_addr;
    logic [MAX_OUT_N-1:0] onehot_full;
    logic [OUT_N-1:0]     load_y_n;

    assign enable = enable_decode(en1_n, en2_n, en3);

    // ">=" rather than "==" so a scan_last lowered below cur_addr mid-scan
    // still returns to 0 on the next advance.
    assign scan_to_zero = (cur_addr >= scan_last);
    assign scan_next    = scan_to_zero ? '0 : cur_addr + ADDR_W'(1);

    // Address that would be loaded this edge in the current state.
    always_comb begin
        load_addr = '0;
        case (state)
            ST_DIRECT: load_addr = addr;
            ST_SCAN:   load_addr = scan_next;
            default:   load_addr = '0;
        endcase
    end

    assign onehot_full = onehot_n(MAX_ADDR_W'(load_addr));
    assign load_y_n    = onehot_full[OUT_N-1:0];

    // The helper is sized for the widest decoder; the upper bits are dropped here.
    generate
        if (OUT_N < MAX_OUT_N) begin : g_hi
            logic unused_hi;
            assign unused_hi = &onehot_full[MAX_OUT_N-1:OUT_N];
        end
    endgenerate

    // Timer is reloaded on scan entry and on every advance.
    assign tmr_load = enable && mode &&
                      ((state == ST_IDLE) || ((state == ST_SCAN) && tmr_done));

    scan_timer #(
        .DWELL_W (DWELL_W)
    ) u_scan_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state == ST_SCAN),
        .load     (tmr_load),
        .load_val (dwell),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            y_n        <= '1;
            cur_addr   <= '0;
            wrap       <= 1'b0;
            addr_ready <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        if (mode) begin
                            state    <= ST_SCAN;
                            y_n      <= load_y_n;
                            cur_addr <= '0;
                        end else begin
                            // Outputs stay all-ones until the first accept.
                            state      <= ST_DIRECT;
                            addr_ready <= 1'b1;
                        end
                    end
                end
                ST_DIRECT: begin
                    if (!enable || mode) begin
                        // Break-before-make: one all-ones cycle in IDLE.
                        state      <= ST_IDLE;
                        y_n        <= '1;
                        cur_addr   <= '0;
                        addr_ready <= 1'b0;
                    end else if (addr_valid && addr_ready) begin
                        y_n      <= load_y_n;
                        cur_addr <= addr;
                    end
                end
                ST_SCAN: begin
                    if (!enable || !mode) begin
                        state      <= ST_IDLE;
                        y_n        <= '1;
                        cur_addr   <= '0;
                        addr_ready <= 1'b0;
                    end else if (tmr_done) begin
                        y_n      <= load_y_n;
                        cur_addr <= scan_next;
                        wrap     <= scan_to_zero;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    y_n        <= '1;
                    cur_addr   <= '0;
                    addr_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: reference model predicts each cycle's outputs.
// Latency: expected values are queued one cycle ahead and compared on the falling edge.
// Backpressure: not applicable.
module tb_decoder_scan;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en1_n, en2_n, en3, mode, addr_valid;
    logic [2:0] addr, scan_last;
    logic [7:0] dwell;
    logic       addr_ready;
    logic [7:0] y_n;
    logic [2:0] cur_addr;
    logic       wrap;

    logic [3:0]  addr4, scan_last4;
    logic        addr_ready4;
    logic [15:0] y_n4;
    logic [3:0]  cur_addr4;
    logic        wrap4;

    decoder_scan #(.ADDR_W(3), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en1_n(en1_n), .en2_n(en2_n), .en3(en3),
        .mode(mode), .addr_valid(addr_valid), .addr(addr), .addr_ready(addr_ready),
        .dwell(dwell), .scan_last(scan_last), .y_n(y_n), .cur_addr(cur_addr), .wrap(wrap)
    );

    decoder_scan #(.ADDR_W(4), .DWELL_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .en1_n(en1_n), .en2_n(en2_n), .en3(en3),
        .mode(mode), .addr_valid(addr_valid), .addr(addr4), .addr_ready(addr_ready4),
        .dwell(dwell), .scan_last(scan_last4), .y_n(y_n4), .cur_addr(cur_addr4), .wrap(wrap4)
    );

    typedef struct packed {
        logic [7:0] y_n;
        logic [2:0] cur;
        logic       ready;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   started = 0;
    int   inv_zeros;

    // Reference model: m_st 0 = off, 1 = direct, 2 = scan.
    // m_sel = selected line (-1 none), m_age = cycles already spent on it,
    // m_hold = dwell captured when it was selected.
    int m_st, m_sel, m_age, m_hold;
    bit m_wrap;

    function automatic exp_t model_out();
        exp_t e;
        e.y_n = 8'hFF;
        e.cur = 3'd0;
        if (m_sel >= 0) begin
            e.y_n[m_sel] = 1'b0;
            e.cur        = 3'(m_sel);
        end
        e.ready = (m_st == 1);
        e.wrap  = m_wrap;
        return e;
    endfunction

    task automatic model_reset();
        m_st = 0; m_sel = -1; m_age = 0; m_hold = 0; m_wrap = 0;
    endtask

    // Effect of the next rising edge given the inputs now applied.
    task automatic model_step();
        bit en;
        en     = en3 && !en1_n && !en2_n;
        m_wrap = 0;
        if (!en) begin
            m_st = 0; m_sel = -1;
        end else if (m_st == 0) begin
            if (mode) begin
                m_st = 2; m_sel = 0; m_age = 0; m_hold = int'(dwell);
            end else begin
                m_st = 1; m_sel = -1;
            end
        end else if ((m_st == 1 && mode) || (m_st == 2 && !mode)) begin
            m_st = 0; m_sel = -1;
        end else if (m_st == 1) begin
            if (addr_valid) m_sel = int'(addr);
        end else begin
            if (m_age == m_hold) begin
                if (m_sel >= int'(scan_last)) begin
                    m_sel  = 0;
                    m_wrap = 1;
                end else begin
                    m_sel = m_sel + 1;
                end
                m_age  = 0;
                m_hold = int'(dwell);
            end else begin
                m_age = m_age + 1;
            end
        end
    endtask

    // One clock of stimulus; called 1 time unit after a rising edge.
    task automatic cyc(input bit e1n, input bit e2n, input bit e3, input bit md, input bit av,
                       input logic [2:0] a, input logic [7:0] dw, input logic [2:0] sl);
        exp_q.push_back(model_out());
        en1_n = e1n; en2_n = e2n; en3 = e3; mode = md; addr_valid = av;
        addr = a; dwell = dw; scan_last = sl;
        addr4 = 4'($urandom_range(15));
        scan_last4 = 4'($urandom_range(15));
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic async_reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (y_n !== 8'hFF || y_n4 !== 16'hFFFF) begin
            n_err++;
            $display("FAIL async_reset: y_n=%h y_n4=%h, required ff / ffff", y_n, y_n4);
        end
        model_reset();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued prediction every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if ({y_n, cur_addr, addr_ready, wrap} !== mon_e) begin
                n_err++;
                $display("FAIL scoreboard t=%0t: y_n=%b cur=%0d rdy=%b wrap=%b, required y_n=%b cur=%0d rdy=%b wrap=%b",
                         $time, y_n, cur_addr, addr_ready, wrap,
                         mon_e.y_n, mon_e.cur, mon_e.ready, mon_e.wrap);
            end
        end
        if (started) begin
            inv_zeros = 0;
            for (int i = 0; i < 16; i++) if (y_n4[i] == 1'b0) inv_zeros++;
            n_cmp++;
            if (!(((inv_zeros == 0 && cur_addr4 == 4'd0) ||
                   (inv_zeros == 1 && y_n4[cur_addr4] == 1'b0)) &&
                  (!wrap4 || (cur_addr4 == 4'd0 && y_n4[0] == 1'b0)) &&
                  !(addr_ready4 && wrap4))) begin
                n_err++;
                $display("FAIL onehot16 t=%0t: y_n4=%b cur4=%0d wrap4=%b rdy4=%b, required single low bit at cur4 or all-ones",
                         $time, y_n4, cur_addr4, wrap4, addr_ready4);
            end
        end
    end

    logic [2:0] r_en, r_sl;
    logic       r_mode;

    initial begin
        rst_n = 1'b1;
        en1_n = 1'b1; en2_n = 1'b1; en3 = 1'b0; mode = 1'b0; addr_valid = 1'b0;
        addr = '0; dwell = '0; scan_last = '0; addr4 = '0; scan_last4 = '0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        started = 1;

        // Direct decode of address 5, then hold with valid low.
        cyc(0, 0, 1, 0, 0, 3'd0, 8'd0, 3'd7);
        cyc(0, 0, 1, 0, 1, 3'd5, 8'd0, 3'd7);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, 0, 3'($urandom_range(7)), 8'd0, 3'd7);

        // Enable sweep while holding address 2.
        cyc(0, 0, 1, 0, 1, 3'd2, 8'd0, 3'd7);
        for (int c = 0; c < 8; c++) begin
            cyc(c[2], c[1], c[0], 0, 0, 3'd0, 8'd0, 3'd7);
            cyc(0, 0, 1, 0, 0, 3'd0, 8'd0, 3'd7);
            cyc(0, 0, 1, 0, 1, 3'd2, 8'd0, 3'd7);
            cyc(0, 0, 1, 0, 0, 3'd0, 8'd0, 3'd7);
        end

        // Scan dwell=2, scan_last=3 (period 12 cycles).
        for (int k = 0; k < 30; k++) cyc(0, 0, 1, 1, 1, 3'($urandom_range(7)), 8'd2, 3'd3);

        // Scan dwell=0, scan_last=7 up to address 5, then lower scan_last to 1.
        for (int k = 0; k < 20 && m_sel != 5; k++) cyc(0, 0, 1, 1, 0, 3'd0, 8'd0, 3'd7);
        for (int k = 0; k < 8; k++) cyc(0, 0, 1, 1, 0, 3'd0, 8'd0, 3'd1);

        // Mode 1 -> 0 mid-scan, then a direct accept.
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 0, 3'd0, 8'd0, 3'd1);
        cyc(0, 0, 1, 0, 1, 3'd6, 8'd0, 3'd1);
        cyc(0, 0, 1, 0, 0, 3'd0, 8'd0, 3'd1);

        // Back to scan, then asynchronous reset mid-scan.
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 1, 0, 3'd0, 8'd1, 3'd7);
        async_reset_pulse();
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 0, 3'd0, 8'd1, 3'd7);

        // Randomised traffic.
        r_mode = 1'b1;
        r_sl   = 3'd7;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) begin
                async_reset_pulse();
            end else begin
                r_en = ($urandom_range(9) != 0) ? 3'b001 : 3'($urandom_range(7));
                if ($urandom_range(19) == 0) r_mode = ~r_mode;
                if ($urandom_range(9) == 0) r_sl = 3'($urandom_range(7));
                cyc(r_en[2], r_en[1], r_en[0], r_mode, 1'($urandom_range(1)),
                    3'($urandom_range(7)), 8'($urandom_range(3)), r_sl);
            end
        end

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Registered, parametrised N-to-2^N decoder with active-low one-hot outputs, three-input enable gating and two modes: direct decode of handshaked addresses, and autonomous scanning of addresses 0..scan_last with a programmable dwell time. It sits between control logic and banks of active-low select/strobe lines (chip selects, LED/keypad row drivers). It guarantees glitch-free, registered outputs with at most one line active.

## Interface
- ADDR_W, 3, address width; OUT_N = 2**ADDR_W is a derived local constant, not overridable
- DWELL_W, 8, width of dwell count
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en1_n, en2_n  in  1 each  active-low enables
- en3  in  1  active-high enable
- mode  in  1  0 = direct decode, 1 = scan
- addr_valid  in  1  direct-mode address valid
- addr  in  ADDR_W  direct-mode address
- addr_ready  out  1  direct-mode address accepted when high with addr_valid
- dwell  in  DWELL_W  scan: each address is held dwell+1 cycles
- scan_last  in  ADDR_W  scan: highest address before wrap
- y_n  out  OUT_N  registered active-low one-hot outputs
- cur_addr  out  ADDR_W  address currently driven low (0 when none)
- wrap  out  1  one-cycle pulse when scan returns to address 0

## Operation
- enable = en3 & !en1_n & !en2_n, sampled each clock edge.
- Invariant: y_n is either all-ones or has exactly one bit low, and that bit index equals cur_addr.
- States: IDLE, DIRECT, SCAN.
- IDLE: y_n all-ones, addr_ready=0, cur_addr=0. If enable and mode=0 -> DIRECT. If enable and mode=1 -> SCAN, starting at address 0 with the dwell counter loaded.
- DIRECT: addr_ready=1. On addr_valid & addr_ready the address is accepted and drives y_n. The output holds until the next accepted address. y_n remains all-ones until the first accept.
- SCAN: addr_ready=0; addr/addr_valid are ignored.
  - Address k is held for dwell+1 cycles. dwell is sampled when each address is loaded.
  - After cur_addr==scan_last, the next address is 0 and wrap=1 for the first cycle of address 0.
  - If cur_addr > scan_last, because scan_last changed mid-scan, the next advance goes to 0 with wrap.
  - scan_last=0: address 0 is held continuously, and wrap pulses every dwell+1 cycles.
- Enable deasserted in any state: next cycle y_n all-ones, state IDLE.
- mode change while in DIRECT or SCAN: state goes to IDLE for exactly one cycle, with outputs all-ones (break-before-make), then enters the new mode.
- Address and dwell arithmetic is unsigned, modulo the field width; no other wrap behaviour exists.

## Timing
- Reset values (async assert, sync release): state IDLE, y_n all-ones, addr_ready 0, cur_addr 0, wrap 0, dwell counter 0.
- All outputs are registered; there is no combinational path from inputs to y_n, cur_addr or wrap.
- addr_ready is a registered state decode, not a function of addr_valid.
- Direct latency: accept on edge T; y_n and cur_addr are updated from edge T onward, visible in cycle T+1.
- Enable/mode to output: 1 cycle to IDLE (all-ones); entry into DIRECT/SCAN takes 1 further cycle.
- Scan start: the first cycle in SCAN shows address 0 with wrap=0. wrap only marks a return from scan_last.
- Reset mid-scan: outputs go all-ones immediately (asynchronously). After release the block restarts from IDLE.

## Structure
- Shared package/include decoder_pkg:
  - state encoding constants ST_IDLE/ST_DIRECT/ST_SCAN
  - function onehot_n(addr) returning ~(1<<addr) over OUT_N bits
  - the enable-decode macro/function, reused by other decoders
- One sub-module, scan_timer: a DWELL_W down-counter with load and a done pulse, instantiated once in decoder_scan.
- The FSM, address register and output register live in decoder_scan.

## Test plan
- Reset, then en3=1, en1_n=en2_n=0, mode=0, addr=5 valid for one cycle -> y_n=8'b1101_1111 one cycle after accept; cur_addr=5; value holds with valid low.
- Enable permutations: en1_n=1, en2_n=1 or en3=0 while in DIRECT at addr=2 -> y_n=8'hFF the next cycle, addr_ready=0. Sweep all 8 enable combinations; only 0/0/1 is active.
- Scan with dwell=2, scan_last=3 -> addresses 0,1,2,3 each for 3 cycles, then 0 with wrap=1 for one cycle. Check the period of 12 cycles.
- Scan with dwell=0, scan_last=7; set scan_last=1 while cur_addr=5 -> the next cycle goes to address 0 with wrap=1, then the scan continues over 0,1 only.
- Switch mode 1->0 mid-scan -> one all-ones cycle, then DIRECT with addr_ready=1 and y_n all-ones until an accept.
- Assert rst_n=0 mid-scan between clock edges -> y_n=8'hFF immediately. Run ADDR_W=4 as a regression: the one-hot invariant holds over 16 outputs.
